// File: rtl/mux_arbiter_2x1_if.sv
// Handshake bundle for the 2:1 arbitrating mux: two upstream lanes, one downstream
// port, and per-lane accepted-beat counters.
interface mux_arbiter_2x1_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_00;
  logic              valid_00;
  logic              ready_00;
  logic [DATA_W-1:0] data_11;
  logic              valid_11;
  logic              ready_11;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_out;
  logic              sel_out;
  logic [7:0]        count_00;
  logic [7:0]        count_11;

  // The arbiter sits on this side: it accepts lane beats and drives the output.
  modport slave (
    input  data_00, valid_00, data_11, valid_11, ready_out,
    output ready_00, ready_11, data_out, valid_out, sel_out, count_00, count_11
  );

  // Upstream lanes plus downstream sink, as seen by whoever drives the arbiter.
  modport master (
    output data_00, valid_00, data_11, valid_11, ready_out,
    input  ready_00, ready_11, data_out, valid_out, sel_out, count_00, count_11
  );
endinterface

// File: rtl/mux_arbiter_2x1.sv
// 2:1 arbitrating mux with a registered output stage, bounded bursts per lane
// (HOLD_MAX) while the other lane waits, and per-lane beat counters.
module mux_arbiter_2x1 #(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk_4f,
  input  logic                reset,
  mux_arbiter_2x1_if.slave    bus,
  output logic [1:0]          state_dbg
);

  // Handshake: a beat moves on any port when its valid and ready are both high in
  // the same cycle. Upstream must hold data/valid stable until its ready is seen;
  // lane ready depends combinationally on valid_out/ready_out, never on lane data.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_MAX);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              last;
  logic              load;
  logic              grant;
  logic              grant_lane;
  logic              own_lane, own_v, oth_v;
  logic              idle_pick;

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              sel_q;
  logic [7:0]        count_00_q, count_11_q;

  assign load      = !valid_q || bus.ready_out;
  assign own_lane  = (state == OWN1);
  assign own_v     = own_lane ? bus.valid_11 : bus.valid_00;
  assign oth_v     = own_lane ? bus.valid_00 : bus.valid_11;
  // From IDLE a tie goes to the lane that did not win last time.
  assign idle_pick = (bus.valid_00 && bus.valid_11) ? ~last : bus.valid_11;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    grant      = 1'b0;
    grant_lane = 1'b0;
    if (load) begin
      case (state)
        IDLE: begin
          if (bus.valid_00 || bus.valid_11) begin
            grant      = 1'b1;
            grant_lane = idle_pick;
            state_nxt  = idle_pick ? OWN1 : OWN0;
            cnt_nxt    = 4'd1;
          end
        end
        OWN0, OWN1: begin
          if (own_v && ((cnt < HOLD) || !oth_v)) begin
            grant      = 1'b1;
            grant_lane = own_lane;
            cnt_nxt    = (cnt < HOLD) ? cnt + 4'd1 : HOLD;
          end else if (oth_v) begin
            grant      = 1'b1;
            grant_lane = ~own_lane;
            state_nxt  = own_lane ? OWN0 : OWN1;
            cnt_nxt    = 4'd1;
          end else begin
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last       <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sel_q      <= 1'b0;
      count_00_q <= 8'd0;
      count_11_q <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        if (grant) begin
          data_q  <= grant_lane ? bus.data_11 : bus.data_00;
          sel_q   <= grant_lane;
          valid_q <= 1'b1;
          last    <= grant_lane;
          if (grant_lane) count_11_q <= count_11_q + 8'd1;
          else            count_00_q <= count_00_q + 8'd1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_00  = !reset && grant && !grant_lane;
  assign bus.ready_11  = !reset && grant && grant_lane;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sel_out   = sel_q;
  assign bus.count_00  = count_00_q;
  assign bus.count_11  = count_11_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mux_arbiter_2x1.sv
// Bench for mux_arbiter_2x1: directed scenarios plus random traffic, checked
// against a fairness-rule reference model and an in-order beat scoreboard.
module tb_mux_arbiter_2x1;
  localparam int DATA_W   = 8;
  localparam int HOLD_MAX = 4;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] state_dbg;

  mux_arbiter_2x1_if #(.DATA_W(DATA_W)) bus ();

  mux_arbiter_2x1 #(.DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk_4f = ~clk_4f;

  int errors = 0;
  int checks = 0;

  logic [DATA_W:0]   exp_q[$];
  bit                pend[2];
  logic [DATA_W-1:0] pdata[2];

  // Reference model: who owns the output, how long the current run is, and
  // whether the last load cycle had no grant (an idle gap).
  bit                m_idle, m_last, m_vout, m_sel;
  int                m_run;
  logic [DATA_W-1:0] m_dout;
  logic [7:0]        m_c0, m_c1;

  function automatic int pick(input bit v0, input bit v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1)  return 0;
    if (v1 && !v0)  return 1;
    if (m_idle)     return m_last ? 0 : 1;
    if (m_run < HOLD_MAX) return int'(m_last);
    return m_last ? 0 : 1;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_last = 1; m_run = 0; m_vout = 0; m_sel = 0;
    m_dout = '0; m_c0 = 8'd0; m_c1 = 8'd0;
    exp_q.delete();
    pend[0] = 0; pend[1] = 0;
  endtask

  task automatic drive_lanes(input bit rdy);
    bus.valid_00  = pend[0];
    bus.data_00   = pend[0] ? pdata[0] : '0;
    bus.valid_11  = pend[1];
    bus.data_11   = pend[1] ? pdata[1] : '0;
    bus.ready_out = rdy;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit w0, input logic [DATA_W-1:0] d0,
                      input bit w1, input logic [DATA_W-1:0] d1, input bit rdy);
    int              g;
    bit              ld;
    bit              sel_b;
    logic [DATA_W:0] beat;
    if (w0 && !pend[0]) begin pend[0] = 1; pdata[0] = d0; end
    if (w1 && !pend[1]) begin pend[1] = 1; pdata[1] = d1; end
    drive_lanes(rdy);
    #1;
    ld = !m_vout || rdy;
    g  = ld ? pick(pend[0], pend[1]) : -1;
    checks++;
    if (bus.ready_00 !== (g == 0) || bus.ready_11 !== (g == 1))
      begin errors++; $display("FAIL lane_ready got=%b%b exp=%b%b", bus.ready_00, bus.ready_11, g == 0, g == 1); end
    if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL out_beat got=%h exp=none (duplicate)", {bus.sel_out, bus.data_out});
      end else begin
        beat = exp_q.pop_front();
        if ({bus.sel_out, bus.data_out} !== beat)
          begin errors++; $display("FAIL out_beat got=%h exp=%h", {bus.sel_out, bus.data_out}, beat); end
      end
    end
    @(posedge clk_4f);
    if (ld) begin
      if (g >= 0) begin
        m_run  = (!m_idle && g == int'(m_last)) ? ((m_run < HOLD_MAX) ? m_run + 1 : HOLD_MAX) : 1;
        m_idle = 0;
        m_last = (g == 1);
        sel_b  = (g == 1);
        m_sel  = sel_b;
        m_dout = pdata[g];
        m_vout = 1;
        if (sel_b) m_c1 = m_c1 + 8'd1; else m_c0 = m_c0 + 8'd1;
        exp_q.push_back({sel_b, pdata[g]});
        pend[g] = 0;
      end else begin
        m_vout = 0;
        m_idle = 1;
      end
    end
    @(negedge clk_4f);
    checks++;
    if (bus.valid_out !== m_vout || bus.sel_out !== m_sel || bus.data_out !== m_dout)
      begin errors++; $display("FAIL out_regs got=%b/%b/%h exp=%b/%b/%h", bus.valid_out, bus.sel_out, bus.data_out, m_vout, m_sel, m_dout); end
    checks++;
    if (bus.count_00 !== m_c0 || bus.count_11 !== m_c1)
      begin errors++; $display("FAIL counts got=%0d/%0d exp=%0d/%0d", bus.count_00, bus.count_11, m_c0, m_c1); end
  endtask

  // Asynchronous reset, checked one time unit after assertion; lanes withdraw too.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive_lanes(1'b1);
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== '0 || bus.sel_out !== 1'b0 ||
        bus.count_00 !== 8'd0 || bus.count_11 !== 8'd0 || bus.ready_00 !== 1'b0 || bus.ready_11 !== 1'b0)
      begin errors++; $display("FAIL reset_state got=v%b d%h s%b c%0d/%0d r%b%b exp=all zero",
        bus.valid_out, bus.data_out, bus.sel_out, bus.count_00, bus.count_11, bus.ready_00, bus.ready_11); end
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    repeat (4) step(0, '0, 0, '0, 1);
    checks++;
    if (exp_q.size() != 0 || pend[0] || pend[1] || bus.valid_out !== 1'b0)
      begin errors++; $display("FAIL %s_drain got=q%0d p%b%b v%b exp=q0 p00 v0", name, exp_q.size(), pend[0], pend[1], bus.valid_out); end
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] exp_d[5];
    bit                exp_s[5];
    exp_d = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C};
    exp_s = '{0, 0, 0, 0, 1};
    @(negedge clk_4f);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hA5, 1, 8'h3C, 1);
      checks++;
      if (bus.data_out !== exp_d[i] || bus.sel_out !== exp_s[i] || bus.valid_out !== 1'b1)
        begin errors++; $display("FAIL first_beats[%0d] got=%h/%b exp=%h/%b", i, bus.data_out, bus.sel_out, exp_d[i], exp_s[i]); end
    end
    drain_and_check("reset");
  endtask

  task automatic test_burst_limit();
    bit exp_s[9];
    exp_s = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 8'($urandom), 1, 8'($urandom), 1);
      checks++;
      if (bus.sel_out !== exp_s[i] || bus.valid_out !== 1'b1)
        begin errors++; $display("FAIL burst_sel[%0d] got=%b/v%b exp=%b/v1", i, bus.sel_out, bus.valid_out, exp_s[i]); end
    end
    drain_and_check("burst");
  endtask

  task automatic test_single_lane();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1, 8'($urandom), 1);
      checks++;
      if (bus.sel_out !== 1'b1 || bus.valid_out !== 1'b1)
        begin errors++; $display("FAIL single_sel[%0d] got=%b/v%b exp=1/v1", i, bus.sel_out, bus.valid_out); end
    end
    checks++;
    if (bus.count_11 !== 8'd10 || bus.count_00 !== 8'd0)
      begin errors++; $display("FAIL single_counts got=%0d/%0d exp=0/10", bus.count_00, bus.count_11); end
    drain_and_check("single");
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] hold_d;
    logic [7:0]        c0, c1;
    do_reset();
    repeat (6) step(1, 8'($urandom), 1, 8'($urandom), 1);
    hold_d = m_dout; c0 = m_c0; c1 = m_c1;
    for (int i = 0; i < 3; i++) begin
      step(1, 8'($urandom), 1, 8'($urandom), 0);
      checks++;
      if (bus.ready_00 !== 1'b0 || bus.ready_11 !== 1'b0 || bus.data_out !== hold_d ||
          bus.count_00 !== c0 || bus.count_11 !== c1 || bus.valid_out !== 1'b1)
        begin errors++; $display("FAIL stall[%0d] got=r%b%b d%h c%0d/%0d exp=r00 d%h c%0d/%0d",
          i, bus.ready_00, bus.ready_11, bus.data_out, bus.count_00, bus.count_11, hold_d, c0, c1); end
    end
    repeat (6) step(1, 8'($urandom), 1, 8'($urandom), 1);
    drain_and_check("backpressure");
  endtask

  task automatic test_idle_handoff();
    do_reset();
    step(1, 8'h01, 0, '0, 1);
    step(1, 8'h02, 0, '0, 1);
    step(0, '0, 0, '0, 1);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h02)
      begin errors++; $display("FAIL idle_gap got=v%b d%h exp=v0 d02", bus.valid_out, bus.data_out); end
    step(1, 8'h11, 1, 8'h22, 1);
    checks++;
    if (bus.sel_out !== 1'b1 || bus.data_out !== 8'h22 || bus.valid_out !== 1'b1)
      begin errors++; $display("FAIL idle_tiebreak got=%b/%h exp=1/22", bus.sel_out, bus.data_out); end
    drain_and_check("handoff");
  endtask

  task automatic test_reset_mid_and_wrap();
    do_reset();
    repeat (3) step(1, 8'($urandom), 1, 8'($urandom), 1);
    checks++;
    if (bus.valid_out !== 1'b1)
      begin errors++; $display("FAIL mid_burst_valid got=%b exp=1", bus.valid_out); end
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1, 8'($urandom), 0, '0, 1);
      if (i == 254) begin
        checks++;
        if (bus.count_00 !== 8'd255)
          begin errors++; $display("FAIL count_255 got=%0d exp=255", bus.count_00); end
      end
    end
    checks++;
    if (bus.count_00 !== 8'd0 || bus.count_11 !== 8'd0)
      begin errors++; $display("FAIL count_wrap got=%0d/%0d exp=0/0", bus.count_00, bus.count_11); end
    drain_and_check("wrap");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 3) != 0);
    drain_and_check("random");
  endtask

  initial begin
    bus.data_00 = '0; bus.valid_00 = 1'b0;
    bus.data_11 = '0; bus.valid_11 = 1'b0;
    bus.ready_out = 1'b1;
    model_reset();
    test_reset();
    test_burst_limit();
    test_single_lane();
    test_backpressure();
    test_idle_handoff();
    test_reset_mid_and_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
